// File: rtl/fetch_pc_ctrl.sv
// ----------------------------------------------------------------------------
// fetch_pc_ctrl
//   Fetch-stage program counter sequencer for the 5-stage pipeline. Owns the
//   PC register and selects the next PC each cycle: PC+4, the EX-resolved
//   branch target, hold (stall), or halt. On a taken branch it squashes the
//   IF/ID and ID/EX registers and opens a FLUSH_CYCLES-long fetch-invalid
//   window.
//
// Parameters:
//   RESET_PC     : PC value loaded on reset.
//   FLUSH_CYCLES : cycles fetch_valid stays low after a redirect (0..7).
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-low reset
//   stall          in   hazard-unit hold, PC frozen this cycle
//   br_taken       in   EX resolved a taken branch this cycle
//   br_pc[63:0]    in   PC of the branch instruction in EX
//   br_offset[63:0] in  signed byte offset (already shifted)
//   halt           in   HALT decoded in ID
//   pc[63:0]       out  current fetch address
//   fetch_valid    out  pc is a valid fetch this cycle
//   flush_if       out  squash IF/ID
//   flush_id       out  squash ID/EX
//   halted         out  controller is in HALT
//
// Optional feature (macro FETCH_PC_CTRL_PERF_EN):
//   redirect_count[31:0] out  accepted taken branches, saturating
//   stall_count[31:0]    out  RUN stall cycles, saturating
// ----------------------------------------------------------------------------
module fetch_pc_ctrl #(
    parameter logic [63:0] RESET_PC     = 64'h0,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [63:0] br_pc,
    input  logic [63:0] br_offset,
    input  logic        halt,
    output logic [63:0] pc,
    output logic        fetch_valid,
    output logic        flush_if,
    output logic        flush_id,
    output logic        halted
`ifdef FETCH_PC_CTRL_PERF_EN
    ,
    output logic [31:0] redirect_count,
    output logic [31:0] stall_count
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_FLUSH,
        ST_HALT
    } state_t;

    // Counter value loaded on a redirect; it counts down to 0 and RUN is
    // entered on the edge where it reads 0, giving FLUSH_CYCLES invalid cycles.
    localparam logic [2:0] CNT_INIT = (FLUSH_CYCLES > 0) ? 3'(FLUSH_CYCLES - 1) : 3'd0;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_pc;
    logic [63:0] w_pc_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;
    logic [63:0] w_target;
    logic        w_active;
    logic        w_redirect;

    assign w_target   = (br_pc + br_offset) & ~64'h3;
    assign w_active   = (r_state == ST_RUN) || (r_state == ST_FLUSH);
    assign w_redirect = w_active && br_taken;
    assign pc         = r_pc;

    // State, PC and flush counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_PC;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state / next-PC selection and outputs
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        fetch_valid = 1'b0;
        flush_if    = 1'b0;
        flush_id    = 1'b0;
        halted      = 1'b0;

        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN, ST_FLUSH: begin
                fetch_valid = (r_state == ST_RUN);
                if (br_taken) begin
                    flush_if = 1'b1;
                    flush_id = 1'b1;
                    w_pc_nxt = w_target;
                    if (FLUSH_CYCLES > 0) begin
                        w_state_nxt = ST_FLUSH;
                        w_cnt_nxt   = CNT_INIT;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end else if (halt) begin
                    w_state_nxt = ST_HALT;
                end else if (r_state == ST_FLUSH) begin
                    // stall is ignored while flushing; the window always drains
                    if (r_cnt == 3'd0) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_cnt_nxt = r_cnt - 3'd1;
                    end
                end else if (!stall) begin
                    w_pc_nxt = r_pc + 64'd4;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

`ifdef FETCH_PC_CTRL_PERF_EN
    logic [31:0] r_redirect_cnt;
    logic [31:0] r_stall_cnt;
    logic        w_run_stall;

    assign w_run_stall = (r_state == ST_RUN) && stall && !br_taken && !halt;

    // Saturating performance counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_redirect_cnt <= '0;
            r_stall_cnt    <= '0;
        end else begin
            if (w_redirect && (r_redirect_cnt != '1)) begin
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
            end
            if (w_run_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign redirect_count = r_redirect_cnt;
    assign stall_count    = r_stall_cnt;
`else
    logic w_unused;
    assign w_unused = w_redirect;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fetch_pc_ctrl
//   Directed stimulus for fetch_pc_ctrl (RESET_PC=0, FLUSH_CYCLES=1). The
//   stimulus process pushes the hand-computed outputs expected for each cycle
//   into a queue; an independent monitor pops and compares at the falling
//   edge. Performance counters are checked when FETCH_PC_CTRL_PERF_EN is set.
// ----------------------------------------------------------------------------
module tb_fetch_pc_ctrl;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        br_taken;
    logic [63:0] br_pc;
    logic [63:0] br_offset;
    logic        halt;
    logic [63:0] pc;
    logic        fetch_valid;
    logic        flush_if;
    logic        flush_id;
    logic        halted;
`ifdef FETCH_PC_CTRL_PERF_EN
    logic [31:0] redirect_count;
    logic [31:0] stall_count;
`endif

    fetch_pc_ctrl #(
        .RESET_PC     (64'h0),
        .FLUSH_CYCLES (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_pc       (br_pc),
        .br_offset   (br_offset),
        .halt        (halt),
        .pc          (pc),
        .fetch_valid (fetch_valid),
        .flush_if    (flush_if),
        .flush_id    (flush_id),
        .halted      (halted)
`ifdef FETCH_PC_CTRL_PERF_EN
        ,
        .redirect_count (redirect_count),
        .stall_count    (stall_count)
`endif
    );

    typedef struct {
        logic [63:0] pc;
        logic        fv;
        logic        fl;
        logic        h;
        logic        perf_chk;
        logic [31:0] rc;
        logic [31:0] sc;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Perf expectations attached to the next pushed vector when set
    logic        g_perf_chk = 1'b0;
    logic [31:0] g_rc = '0;
    logic [31:0] g_sc = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1);
    end

    // Monitor: compares one expected vector per cycle at the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_checks++;
                if (pc !== e.pc || fetch_valid !== e.fv || flush_if !== e.fl ||
                    flush_id !== e.fl || halted !== e.h) begin
                    n_errors++;
                    $display("FAIL %s: got pc=%h fv=%b fi=%b fd=%b h=%b, required pc=%h fv=%b fi=%b fd=%b h=%b",
                             e.name, pc, fetch_valid, flush_if, flush_id, halted,
                             e.pc, e.fv, e.fl, e.fl, e.h);
                end
`ifdef FETCH_PC_CTRL_PERF_EN
                if (e.perf_chk) begin
                    n_checks++;
                    if (redirect_count !== e.rc || stall_count !== e.sc) begin
                        n_errors++;
                        $display("FAIL %s_perf: got rc=%0d sc=%0d, required rc=%0d sc=%0d",
                                 e.name, redirect_count, stall_count, e.rc, e.sc);
                    end
                end
`endif
            end
        end
    end

    task automatic push_exp(input logic [63:0] epc, input logic efv, input logic efl,
                            input logic eh, input string nm);
        exp_t e;
        e.pc       = epc;
        e.fv       = efv;
        e.fl       = efl;
        e.h        = eh;
        e.perf_chk = g_perf_chk;
        e.rc       = g_rc;
        e.sc       = g_sc;
        e.name     = nm;
        q.push_back(e);
    endtask

    // Drive one cycle of inputs (called at posedge+1), queue that cycle's
    // expected outputs, then advance to the next posedge+1.
    task automatic cyc(input logic s, input logic b, input logic [63:0] bp,
                       input logic [63:0] bo, input logic h,
                       input logic [63:0] epc, input logic efv, input logic efl,
                       input logic eh, input string nm);
        stall     = s;
        br_taken  = b;
        br_pc     = bp;
        br_offset = bo;
        halt      = h;
        push_exp(epc, efv, efl, eh, nm);
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] NEG40 = 64'hFFFF_FFFF_FFFF_FFD8;
    localparam logic [63:0] TOPW  = 64'hFFFF_FFFF_FFFF_FFFC;

    initial begin
        reset     = 1'b0;
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_pc     = '0;
        br_offset = '0;
        halt      = 1'b0;
        @(posedge clk);
        #1;

        // Reset: branch request must not flush
        g_perf_chk = 1'b1; g_rc = 32'd0; g_sc = 32'd0;
        cyc(1'b0, 1'b1, 64'd8, 64'd40, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, "reset");
        g_perf_chk = 1'b0;
        reset = 1'b1;
        // BOOT ignores every input
        cyc(1'b1, 1'b1, 64'd8, 64'd40, 1'b1, 64'd0, 1'b0, 1'b0, 1'b0, "boot");
        cyc(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0,  1'b1, 1'b0, 1'b0, "run_pc0");
        cyc(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 64'd4,  1'b1, 1'b0, 1'b0, "run_pc4");
        cyc(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 64'd8,  1'b1, 1'b0, 1'b0, "run_pc8");
        // Forward branch 8+40=48
        cyc(1'b0, 1'b1, 64'd8, 64'd40, 1'b0, 64'd12, 1'b1, 1'b1, 1'b0, "br_fwd");
        // FLUSH cycle; stall ignored
        cyc(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 64'd48, 1'b0, 1'b0, 1'b0, "flush48");
        cyc(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 64'd48, 1'b1, 1'b0, 1'b0, "run_pc48");
        // Backward branch 56-40=16
        cyc(1'b0, 1'b1, 64'd56, NEG40, 1'b0, 64'd52, 1'b1, 1'b1, 1'b0, "br_back");
        // Redirect again from FLUSH, wrapping FF..FC+8=4
        cyc(1'b0, 1'b1, TOPW, 64'd8, 1'b0, 64'd16, 1'b0, 1'b1, 1'b0, "br_wrap_in_flush");
        cyc(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 64'd4,  1'b0, 1'b0, 1'b0, "flush4");
        cyc(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 64'd4,  1'b1, 1'b0, 1'b0, "run_pc4b");
        cyc(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 64'd8,  1'b1, 1'b0, 1'b0, "run_pc8b");
        cyc(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 64'd12, 1'b1, 1'b0, 1'b0, "run_pc12b");
        cyc(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 64'd16, 1'b1, 1'b0, 1'b0, "run_pc16b");
        // Three stall cycles at 20
        for (int unsigned i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 64'd20, 1'b1, 1'b0, 1'b0, "stall20");
        end
        cyc(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 64'd20, 1'b1, 1'b0, 1'b0, "resume20");
        // Stall and branch together: branch wins, 0+100=100
        cyc(1'b1, 1'b1, 64'd0, 64'd100, 1'b0, 64'd24, 1'b1, 1'b1, 1'b0, "stall_vs_br");
        cyc(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 64'd100, 1'b0, 1'b0, 1'b0, "flush100");
        // Misaligned target 0+30 -> 28 (low bits cleared)
        cyc(1'b0, 1'b1, 64'd0, 64'd30, 1'b0, 64'd100, 1'b1, 1'b1, 1'b0, "br_align");
        cyc(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 64'd28, 1'b0, 1'b0, 1'b0, "flush28");
        cyc(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 64'd28, 1'b1, 1'b0, 1'b0, "run_pc28");
        // HALT at 32
        cyc(1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 64'd32, 1'b1, 1'b0, 1'b0, "halt_req");
        g_perf_chk = 1'b1; g_rc = 32'd5; g_sc = 32'd3;
        for (int unsigned i = 0; i < 5; i++) begin
            cyc(i[0], ~i[0], 64'd0, 64'd100, 1'b1, 64'd32, 1'b0, 1'b0, 1'b1, "halted");
        end
        // Asynchronous reset mid-cycle, compared before the next clock edge
        #2;
        reset = 1'b0;
        g_rc = 32'd0; g_sc = 32'd0;
        push_exp(64'd0, 1'b0, 1'b0, 1'b0, "async_reset");
        g_perf_chk = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, "reset_held");
        reset = 1'b1;
        cyc(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, "boot2");
        cyc(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, "run2_pc0");
        cyc(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 64'd4, 1'b1, 1'b0, 1'b0, "run2_pc4");

        // Let the monitor drain the queue, bounded
        for (int unsigned i = 0; i < 4 && q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
